// File: rtl/golomb_gpo2_encoder_pkg.sv
// Shared types and width helpers for the length-limited GPO2 sample encoder.
package golomb_pkg;

   localparam int DMAX  = 32;
   localparam int KWMAX = 5;

   typedef enum logic [1:0] {RAW, NORMAL, ESCAPE} mode_e;

   // Fixed at the widest legal sample so one struct serves every D.
   typedef struct packed {
      logic [DMAX-1:0]  j;
      logic [KWMAX-1:0] keff;
      logic             raw;
      logic             kerr;
   } s1_payload_t;

   function automatic int len_w(input int umax, input int d);
      return $clog2(umax + d + 1);
   endfunction

   function automatic int k_w(input int d);
      return (d > 1) ? $clog2(d) : 1;
   endfunction

endpackage

// File: rtl/golomb_gpo2_encoder_code_calc.sv
// Combinational codeword builder between the two pipeline stages: quotient,
// escape decision, masked remainder and total length.
module gpo2_code_calc
   import golomb_pkg::*;
#(
   parameter int D     = 16,
   parameter int UMAX  = 18,
   parameter int K_W   = k_w(D),
   parameter int LEN_W = len_w(UMAX, D)
) (
   input  logic [D-1:0]     j_i,
   input  logic [K_W-1:0]   keff_i,
   input  logic             raw_i,
   output logic [D:0]       code_o,
   output logic [LEN_W-1:0] len_o,
   output logic             esc_o
);

   localparam int DW1 = D + 1;

   logic [D-1:0] u;
   logic [D-1:0] rem;
   logic [D:0]   lead;
   mode_e        mode;

   always_comb begin
      u    = j_i >> keff_i;
      rem  = j_i & ((D'(1) << keff_i) - D'(1));
      lead = DW1'(1) << keff_i;

      // Full-width quotient compare; a narrowed u could hide an escape.
      if (raw_i) begin
         mode = RAW;
      end else if (33'(u) >= 33'(UMAX)) begin
         mode = ESCAPE;
      end else begin
         mode = NORMAL;
      end

      code_o = {1'b0, j_i};
      len_o  = LEN_W'(D);
      esc_o  = 1'b0;
      case (mode)
         NORMAL: begin
            code_o = lead | {1'b0, rem};
            len_o  = LEN_W'(u) + LEN_W'(keff_i) + LEN_W'(1);
         end
         ESCAPE: begin
            len_o = LEN_W'(UMAX + D);
            esc_o = 1'b1;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/golomb_gpo2_encoder.sv
// Length-limited Golomb power-of-2 sample encoder: two-stage valid/ready
// pipeline with raw mode, k clamping and a saturating escape counter.
module golomb_gpo2_encoder
   import golomb_pkg::*;
#(
   parameter int D     = 16,
   parameter int UMAX  = 18,
   parameter int KMAX  = D - 2,
   parameter int CNT_W = 32,
   localparam int K_W   = k_w(D),
   localparam int LEN_W = len_w(UMAX, D)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [D-1:0]     in_data,
   input  logic [K_W-1:0]   in_k,
   input  logic             in_raw,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [D:0]       out_code,
   output logic [LEN_W-1:0] out_len,
   output logic             out_esc,
   output logic             out_kerr,
   output logic [CNT_W-1:0] esc_cnt,
   input  logic             cnt_clr
);

   if (D < 2 || D > DMAX) begin : g_bad_d
      $error("golomb_gpo2_encoder: D out of range");
   end
   if (UMAX < 8 || UMAX > 32) begin : g_bad_umax
      $error("golomb_gpo2_encoder: UMAX out of range");
   end
   if (KMAX < 0 || KMAX > D - 1) begin : g_bad_kmax
      $error("golomb_gpo2_encoder: KMAX out of range");
   end
   if (UMAX + D > (1 << LEN_W) - 1) begin : g_bad_len
      $error("golomb_gpo2_encoder: UMAX+D does not fit in LEN_W");
   end

   logic             v1_q, v1_d, v2_q, v2_d;
   s1_payload_t      s1_q, s1_d;
   logic [D:0]       code_q, code_d;
   logic [LEN_W-1:0] len_q, len_d;
   logic             esc_q, esc_d, kerr_q, kerr_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic             s1_en, s2_en, k_over;
   logic [K_W-1:0]   keff_in;
   logic [D:0]       calc_code;
   logic [LEN_W-1:0] calc_len;
   logic             calc_esc;
   logic             unused_s1_bits;

   assign unused_s1_bits = ^{s1_q.j, s1_q.keff};

   gpo2_code_calc #(
      .D     (D),
      .UMAX  (UMAX),
      .K_W   (K_W),
      .LEN_W (LEN_W)
   ) u_calc (
      .j_i    (s1_q.j[D-1:0]),
      .keff_i (s1_q.keff[K_W-1:0]),
      .raw_i  (s1_q.raw),
      .code_o (calc_code),
      .len_o  (calc_len),
      .esc_o  (calc_esc)
   );

   always_comb begin
      s2_en   = !v2_q || out_ready;
      s1_en   = !v1_q || s2_en;
      k_over  = int'(in_k) > KMAX;
      keff_in = k_over ? K_W'(KMAX) : in_k;

      s1_d = s1_q;
      if (s1_en && in_valid) begin
         s1_d.j    = DMAX'(in_data);
         s1_d.keff = KWMAX'(keff_in);
         s1_d.raw  = in_raw;
         s1_d.kerr = k_over && !in_raw;
      end
      v1_d = s1_en ? in_valid : v1_q;
      v2_d = s2_en ? v1_q : v2_q;

      // Output registers only move when a real sample advances, so a
      // stalled codeword stays put.
      code_d = code_q;
      len_d  = len_q;
      esc_d  = esc_q;
      kerr_d = kerr_q;
      if (s2_en && v1_q) begin
         code_d = calc_code;
         len_d  = calc_len;
         esc_d  = calc_esc;
         kerr_d = s1_q.kerr;
      end

      cnt_d = cnt_q;
      if (cnt_clr) begin
         cnt_d = '0;
      end else if (v2_q && out_ready && esc_q && !(&cnt_q)) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v1_q   <= 1'b0;
         v2_q   <= 1'b0;
         s1_q   <= '0;
         code_q <= '0;
         len_q  <= '0;
         esc_q  <= 1'b0;
         kerr_q <= 1'b0;
         cnt_q  <= '0;
      end else begin
         v1_q   <= v1_d;
         v2_q   <= v2_d;
         s1_q   <= s1_d;
         code_q <= code_d;
         len_q  <= len_d;
         esc_q  <= esc_d;
         kerr_q <= kerr_d;
         cnt_q  <= cnt_d;
      end
   end

   assign in_ready  = s1_en;
   assign out_valid = v2_q;
   assign out_code  = code_q;
   assign out_len   = len_q;
   assign out_esc   = esc_q;
   assign out_kerr  = kerr_q;
   assign esc_cnt   = cnt_q;

endmodule
